// File: rtl/wheel_pulse_meter_pkg.sv
// Shared constants and state encodings for the smart-car measurement blocks.
package wheel_pulse_meter_pkg;

  localparam int SYS_CLK_HZ          = 50_000_000;
  localparam int DEFAULT_GATE_CYCLES = 5_000_000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } per_state_e;

endpackage

// File: rtl/wheel_pulse_meter_edge_sync.sv
// Two-flop synchroniser plus history flop; flags a rising edge of an async input.
module pulse_edge_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic d_async,
  output logic edge_det
);

  logic s1, s2, s3;

  // The chain keeps sampling during reset so the history tracks a held-high input
  // and no false edge appears on release; consumers ignore edge_det while in reset.
  always_ff @(posedge clk_in) begin
    s1 <= d_async;
    s2 <= s1;
    s3 <= s2;
  end

  assign edge_det = s2 & ~s3;

endmodule

// File: rtl/wheel_pulse_meter.sv
// Gate-window edge counter and edge-to-edge period meter for an external pulse train.
module wheel_pulse_meter
  import wheel_pulse_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int CW          = 16,
  parameter int PW          = 24
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          sig_in,
  output logic [CW-1:0] freq_count,
  output logic          freq_ovf,
  output logic          freq_valid,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          stalled
);

  localparam int            WW       = $clog2(GATE_CYCLES);
  localparam logic [WW-1:0] WIN_LAST = WW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [PW-1:0] PER_MAX  = '1;

  logic          edge_det;
  logic [WW-1:0] win_cnt;
  logic [CW-1:0] edge_cnt;
  logic          edge_ovf;
  logic [CW:0]   cnt_sum;
  logic [CW-1:0] cnt_next;
  logic          ovf_next;

  per_state_e    state, state_n;
  logic [PW-1:0] per_cnt, per_cnt_n;
  logic [PW-1:0] period_n;
  logic          period_valid_n;
  logic          stalled_n;

  pulse_edge_sync u_sync (
    .clk_in  (clk_in),
    .rst     (rst),
    .d_async (sig_in),
    .edge_det(edge_det)
  );

  // Overflow is sticky: it records that the true count went past CNT_MAX.
  always_comb begin
    cnt_sum  = {1'b0, edge_cnt} + (CW + 1)'(edge_det);
    cnt_next = cnt_sum[CW] ? CNT_MAX : cnt_sum[CW-1:0];
    ovf_next = edge_ovf | cnt_sum[CW];
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      win_cnt    <= '0;
      edge_cnt   <= '0;
      edge_ovf   <= 1'b0;
      freq_count <= '0;
      freq_ovf   <= 1'b0;
      freq_valid <= 1'b0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt    <= '0;
      edge_cnt   <= '0;
      edge_ovf   <= 1'b0;
      freq_count <= cnt_next;
      freq_ovf   <= ovf_next;
      freq_valid <= 1'b1;
    end else begin
      win_cnt    <= win_cnt + WW'(1);
      edge_cnt   <= cnt_next;
      edge_ovf   <= ovf_next;
      freq_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= ST_IDLE;
      per_cnt      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      state        <= state_n;
      per_cnt      <= per_cnt_n;
      period       <= period_n;
      period_valid <= period_valid_n;
      stalled      <= stalled_n;
    end
  end

  // An edge in the same cycle the counter tops out still yields a period of PER_MAX.
  always_comb begin
    state_n        = state;
    per_cnt_n      = per_cnt;
    period_n       = period;
    period_valid_n = 1'b0;
    stalled_n      = stalled;
    case (state)
      ST_IDLE: begin
        if (edge_det) begin
          state_n   = ST_ARMED;
          per_cnt_n = PW'(1);
        end
      end
      ST_ARMED: begin
        if (edge_det) begin
          period_n       = per_cnt;
          period_valid_n = 1'b1;
          stalled_n      = 1'b0;
          per_cnt_n      = PW'(1);
        end else if (per_cnt == PER_MAX) begin
          state_n   = ST_IDLE;
          period_n  = '0;
          stalled_n = 1'b1;
          per_cnt_n = '0;
        end else begin
          per_cnt_n = per_cnt + PW'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_wheel_pulse_meter.sv
// Scoreboard bench: plans an edge schedule, predicts window counts, periods and stall
// points from it, then plays it with random sub-cycle phase and compares DUT strobes.
module tb_wheel_pulse_meter;

  localparam int GATE    = 1000;
  localparam int PER_MAX = 4095;
  localparam int END_P   = 22100;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        sig_in;
  logic [15:0] freq_count_a;
  logic        freq_ovf_a, freq_valid_a;
  logic [11:0] period_a;
  logic        period_valid_a, stalled_a;
  logic [3:0]  freq_count_b;
  logic        freq_ovf_b, freq_valid_b;
  logic [11:0] period_b;
  logic        period_valid_b, stalled_b;

  typedef struct {int at; int cnt; int cnt4; int ovf4;} freq_exp_t;
  typedef struct {int at; int per;} per_exp_t;

  freq_exp_t freq_q[$];
  per_exp_t  per_q[$];
  int        stall_q[$];
  int        sched[$];
  int        pcnt;
  int        n_compared = 0;
  int        n_mismatched = 0;
  bit        mon_en = 0;
  logic      prev_fv, prev_pv, prev_st;

  wheel_pulse_meter #(.GATE_CYCLES(GATE), .CW(16), .PW(12)) dut_a (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in),
    .freq_count(freq_count_a), .freq_ovf(freq_ovf_a), .freq_valid(freq_valid_a),
    .period(period_a), .period_valid(period_valid_a), .stalled(stalled_a)
  );

  wheel_pulse_meter #(.GATE_CYCLES(GATE), .CW(4), .PW(12)) dut_b (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in),
    .freq_count(freq_count_b), .freq_ovf(freq_ovf_b), .freq_valid(freq_valid_b),
    .period(period_b), .period_valid(period_valid_b), .stalled(stalled_b)
  );

  always #5 clk_in = ~clk_in;

  // pcnt equals (index of the last posedge since reset release) + 1.
  always @(posedge clk_in) begin
    if (rst) pcnt <= 0;
    else     pcnt <= pcnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (pcnt=%0d)", tag, obs, exp, pcnt);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_freq_count"}, freq_count_a, 0);
    checkOutput({tag, "_freq_ovf"}, freq_ovf_a, 0);
    checkOutput({tag, "_freq_valid"}, freq_valid_a, 0);
    checkOutput({tag, "_period"}, period_a, 0);
    checkOutput({tag, "_period_valid"}, period_valid_a, 0);
    checkOutput({tag, "_stalled"}, stalled_a, 0);
    checkOutput({tag, "_freq_count_b"}, freq_count_b, 0);
    checkOutput({tag, "_freq_ovf_b"}, freq_ovf_b, 0);
  endtask

  // A rise driven while pcnt==p is first sampled at the next posedge and is
  // counted two posedges later, so scheduled edge e is driven when pcnt==e-2.
  task automatic applyStimulus(input int end_p);
    int idx = 0;
    int unsigned d;
    while (pcnt < end_p) begin
      @(posedge clk_in);
      d = $urandom_range(1, 8);
      #(d);
      if (idx < sched.size() && sched[idx] == pcnt + 2) begin
        sig_in = 1'b1;
        idx++;
      end else begin
        sig_in = 1'b0;
      end
    end
    sig_in = 1'b0;
  endtask

  task automatic buildPlan();
    int e, g, cnt;
    int hist[32];
    for (int j = 0; j < 75; j++) sched.push_back(20 + 40 * j);
    sched.push_back(7999);
    sched.push_back(8099);
    for (int j = 0; j < 50; j++) sched.push_back(9000 + 20 * j);
    for (int j = 0; j < 10; j++) sched.push_back(10050 + 100 * j);
    sched.push_back(10950 + PER_MAX);
    sched.push_back(10950 + PER_MAX + PER_MAX + 1);
    e = 10950 + 2 * PER_MAX + 1 + 50;
    sched.push_back(e);
    forever begin
      g = $urandom_range(4, 60);
      if (e + g > 21900) break;
      e += g;
      sched.push_back(e);
    end
    for (int k = 0; k < 32; k++) hist[k] = 0;
    foreach (sched[i]) hist[sched[i] / GATE]++;
    for (int k = 0; k < END_P / GATE; k++) begin
      cnt = hist[k];
      freq_q.push_back('{at: (k + 1) * GATE, cnt: cnt,
                         cnt4: (cnt > 15) ? 15 : cnt, ovf4: (cnt > 15) ? 1 : 0});
    end
    for (int i = 1; i < sched.size(); i++) begin
      g = sched[i] - sched[i-1];
      if (i > 1 && sched[i-1] - sched[i-2] > PER_MAX) begin
        // previous edge only re-armed the meter after a stall
        if (g <= PER_MAX) per_q.push_back('{at: sched[i] + 1, per: g});
        else              stall_q.push_back(sched[i-1] + PER_MAX + 1);
      end else if (g <= PER_MAX) begin
        per_q.push_back('{at: sched[i] + 1, per: g});
      end else begin
        stall_q.push_back(sched[i-1] + PER_MAX + 1);
      end
    end
  endtask

  always @(negedge clk_in) begin
    freq_exp_t fe;
    per_exp_t  pe;
    int        sa;
    if (!mon_en || rst) begin
      prev_fv = 1'b0;
      prev_pv = 1'b0;
      prev_st = 1'b0;
    end else begin
      if (freq_valid_a) begin
        checkOutput("freq_width", prev_fv, 0);
        checkOutput("freq_valid_b_align", freq_valid_b, 1);
        if (freq_q.size() == 0) checkOutput("freq_extra", 1, 0);
        else begin
          fe = freq_q.pop_front();
          checkOutput("freq_at", pcnt, fe.at);
          checkOutput("freq_count", freq_count_a, fe.cnt);
          checkOutput("freq_ovf", freq_ovf_a, 0);
          checkOutput("freq_count_cw4", freq_count_b, fe.cnt4);
          checkOutput("freq_ovf_cw4", freq_ovf_b, fe.ovf4);
        end
      end
      if (period_valid_a) begin
        checkOutput("period_width", prev_pv, 0);
        checkOutput("stalled_clr", stalled_a, 0);
        if (per_q.size() == 0) checkOutput("period_extra", 1, 0);
        else begin
          pe = per_q.pop_front();
          checkOutput("period_at", pcnt, pe.at);
          checkOutput("period", period_a, pe.per);
        end
      end
      if (stalled_a && !prev_st) begin
        checkOutput("stall_period", period_a, 0);
        if (stall_q.size() == 0) checkOutput("stall_extra", 1, 0);
        else begin
          sa = stall_q.pop_front();
          checkOutput("stall_at", pcnt, sa);
        end
      end
      prev_fv = freq_valid_a;
      prev_pv = period_valid_a;
      prev_st = stalled_a;
    end
  end

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;
    buildPlan();
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    checkReset("rst1");
    @(posedge clk_in);
    #2 rst = 1'b0;
    mon_en = 1;
    applyStimulus(END_P);
    repeat (3) @(posedge clk_in);
    checkOutput("freq_q_left", freq_q.size(), 0);
    checkOutput("period_q_left", per_q.size(), 0);
    checkOutput("stall_q_left", stall_q.size(), 0);

    // Reset mid-window and mid-period with the input held high.
    @(posedge clk_in);
    #2;
    mon_en = 0;
    sig_in = 1'b1;
    rst    = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checkReset("rst2");
    freq_q.push_back('{at: GATE, cnt: 0, cnt4: 0, ovf4: 0});
    @(posedge clk_in);
    #2 rst = 1'b0;
    mon_en = 1;
    repeat (GATE + 10) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("rst2_freq_q_left", freq_q.size(), 0);
    checkOutput("rst2_no_period", per_q.size(), 0);
    checkOutput("rst2_stalled", stalled_a, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
